// File: rtl/controller_fsm_pkg.sv
// Shared constants for the controller and datapath: state codes,
// ALU op codes and bus-driver select positions.
package controller_fsm_pkg;

   typedef enum logic [2:0] {
      S_LOAD_A = 3'd0,
      S_LOAD_B = 3'd1,
      S_MAX    = 3'd2,
      S_MIN    = 3'd3,
      S_APPROX = 3'd4,
      S_FINAL  = 3'd5,
      S_OUT    = 3'd6,
      S_DONE   = 3'd7
   } state_e;

   localparam logic [1:0] ALU_PASS   = 2'b00;
   localparam logic [1:0] ALU_MAX    = 2'b01;
   localparam logic [1:0] ALU_MIN    = 2'b10;
   localparam logic [1:0] ALU_APPROX = 2'b11;

   localparam int TRI_IN  = 0;
   localparam int TRI_ALU = 1;
   localparam int TRI_R3  = 2;

   function automatic logic [7:0] tri_sel(input int bit_pos);
      logic [7:0] v;
      v = '0;
      v[bit_pos] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/controller_fsm.sv
// Moore sequencer for the abs/max/min/approx datapath: eight states,
// outputs decoded from state only, synchronous restart on start.
module controller_fsm
   import controller_fsm_pkg::*;
(
   input  logic       clk,
   input  logic       start,
   output logic [2:0] state,
   output logic       WER1,
   output logic [2:0] WAR1,
   output logic       RER1,
   output logic [2:0] RAR1,
   output logic       WER2,
   output logic [2:0] WAR2,
   output logic       RER2,
   output logic [2:0] RAR2,
   output logic       ALU1,
   output logic [1:0] ALU2,
   output logic       WER3,
   output logic       RR3,
   output logic       OE,
   output logic [7:0] trictrl,
   output logic       done
);

   state_e state_q;
   state_e state_d;

   always_ff @(posedge clk) begin
      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = S_LOAD_A;
      end else if (state_q != S_DONE) begin
         state_d = state_e'(state_q + 3'd1);
      end
   end

   assign state = state_q;

   always_comb begin
      WER1    = 1'b0;
      WAR1    = 3'd0;
      RER1    = 1'b0;
      RAR1    = 3'd0;
      WER2    = 1'b0;
      WAR2    = 3'd0;
      RER2    = 1'b0;
      RAR2    = 3'd0;
      ALU1    = 1'b0;
      ALU2    = ALU_PASS;
      WER3    = 1'b0;
      RR3     = 1'b0;
      OE      = 1'b0;
      trictrl = 8'h00;
      done    = 1'b0;
      unique case (state_q)
         S_LOAD_A: begin
            WER1    = 1'b1;
            WER2    = 1'b1;
            trictrl = tri_sel(TRI_IN);
         end
         S_LOAD_B: begin
            WER1    = 1'b1;
            WAR1    = 3'd1;
            WER2    = 1'b1;
            WAR2    = 3'd1;
            trictrl = tri_sel(TRI_IN);
         end
         S_MAX: begin
            RER1    = 1'b1;
            RER2    = 1'b1;
            RAR2    = 3'd1;
            ALU1    = 1'b1;
            ALU2    = ALU_MAX;
            WER1    = 1'b1;
            WAR1    = 3'd2;
            trictrl = tri_sel(TRI_ALU);
         end
         S_MIN: begin
            RER1    = 1'b1;
            RER2    = 1'b1;
            RAR2    = 3'd1;
            ALU1    = 1'b1;
            ALU2    = ALU_MIN;
            WER2    = 1'b1;
            WAR2    = 3'd2;
            trictrl = tri_sel(TRI_ALU);
         end
         S_APPROX: begin
            RER1    = 1'b1;
            RAR1    = 3'd2;
            RER2    = 1'b1;
            RAR2    = 3'd2;
            ALU2    = ALU_APPROX;
            WER2    = 1'b1;
            WAR2    = 3'd3;
            trictrl = tri_sel(TRI_ALU);
         end
         S_FINAL: begin
            RER1    = 1'b1;
            RAR1    = 3'd2;
            RER2    = 1'b1;
            RAR2    = 3'd3;
            ALU2    = ALU_MAX;
            WER3    = 1'b1;
            trictrl = tri_sel(TRI_ALU);
         end
         S_OUT: begin
            RR3     = 1'b1;
            OE      = 1'b1;
            trictrl = tri_sel(TRI_R3);
         end
         S_DONE: begin
            RR3     = 1'b1;
            OE      = 1'b1;
            done    = 1'b1;
            trictrl = tri_sel(TRI_R3);
         end
      endcase
   end

endmodule

// File: tb/tb_controller_fsm.sv
// Bench for controller_fsm: saturating step-count model plus a per-step
// output table, directed scenarios and a randomized start pattern.
module tb_controller_fsm;

   logic       clk;
   logic       start;
   logic [2:0] state;
   logic       WER1, RER1, WER2, RER2, ALU1, WER3, RR3, OE, done;
   logic [2:0] WAR1, RAR1, WAR2, RAR2;
   logic [1:0] ALU2;
   logic [7:0] trictrl;

   int checks = 0;
   int errors = 0;
   int m_step = 0;

   controller_fsm dut (
      .clk(clk), .start(start), .state(state),
      .WER1(WER1), .WAR1(WAR1), .RER1(RER1), .RAR1(RAR1),
      .WER2(WER2), .WAR2(WAR2), .RER2(RER2), .RAR2(RAR2),
      .ALU1(ALU1), .ALU2(ALU2), .WER3(WER3), .RR3(RR3),
      .OE(OE), .trictrl(trictrl), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wire [33:0] dut_vec = {state, WER1, WAR1, RER1, RAR1,
                          WER2, WAR2, RER2, RAR2, ALU1, ALU2,
                          WER3, RR3, OE, trictrl, done};

   // Expected outputs for step s, straight from the per-state table
   function automatic logic [33:0] exp_vec(input int s);
      logic [2:0] st, war1, rar1, war2, rar2;
      logic       wer1, rer1, wer2, rer2, alu1, wer3, rr3, oe, dn;
      logic [1:0] alu2;
      logic [7:0] tc;
      st = 3'(s);
      {wer1, war1, rer1, rar1, wer2, war2, rer2, rar2} = '0;
      {alu1, alu2, wer3, rr3, oe, tc, dn} = '0;
      case (s)
         0: begin wer1 = 1; wer2 = 1; tc = 8'h01; end
         1: begin wer1 = 1; war1 = 1; wer2 = 1; war2 = 1; tc = 8'h01; end
         2: begin rer1 = 1; rer2 = 1; rar2 = 1; alu1 = 1; alu2 = 2'b01;
                  wer1 = 1; war1 = 2; tc = 8'h02; end
         3: begin rer1 = 1; rer2 = 1; rar2 = 1; alu1 = 1; alu2 = 2'b10;
                  wer2 = 1; war2 = 2; tc = 8'h02; end
         4: begin rer1 = 1; rar1 = 2; rer2 = 1; rar2 = 2; alu2 = 2'b11;
                  wer2 = 1; war2 = 3; tc = 8'h02; end
         5: begin rer1 = 1; rar1 = 2; rer2 = 1; rar2 = 3; alu2 = 2'b01;
                  wer3 = 1; tc = 8'h02; end
         6: begin rr3 = 1; oe = 1; tc = 8'h04; end
         default: begin rr3 = 1; oe = 1; dn = 1; tc = 8'h04; end
      endcase
      return {st, wer1, war1, rer1, rar1, wer2, war2, rer2, rar2,
              alu1, alu2, wer3, rr3, oe, tc, dn};
   endfunction

   task automatic tick(input logic s);
      start = s;
      @(posedge clk);
      m_step = s ? 0 : ((m_step >= 7) ? 7 : m_step + 1);
      #1;
   endtask

   task automatic test_reset;
      tick(1'b1);
      checks++;
      if (dut_vec !== exp_vec(0)) begin
         errors++;
         $display("FAIL reset: got %h want %h", dut_vec, exp_vec(0));
      end
   endtask

   task automatic test_sequence;
      int lat;
      tick(1'b1);
      lat = 0;
      for (int i = 0; i < 9; i++) begin
         tick(1'b0);
         if (lat == 0 && done === 1'b1) lat = i + 1;
         checks++;
         if (dut_vec !== exp_vec(m_step)) begin
            errors++;
            $display("FAIL seq[%0d]: got %h want %h",
                     i, dut_vec, exp_vec(m_step));
         end
      end
      checks++;
      if (lat != 7) begin
         errors++;
         $display("FAIL latency: got %0d want 7", lat);
      end
   endtask

   task automatic test_restart_mid;
      tick(1'b1);
      for (int i = 0; i < 4; i++) tick(1'b0);
      checks++;
      if (state !== 3'd4) begin
         errors++;
         $display("FAIL mid_pre: state %0d want 4", state);
      end
      tick(1'b1);
      checks++;
      if (dut_vec !== exp_vec(0)) begin
         errors++;
         $display("FAIL mid_restart: got %h want %h", dut_vec, exp_vec(0));
      end
      for (int i = 0; i < 8; i++) begin
         tick(1'b0);
         checks++;
         if (dut_vec !== exp_vec(m_step)) begin
            errors++;
            $display("FAIL mid_seq[%0d]: got %h want %h",
                     i, dut_vec, exp_vec(m_step));
         end
      end
   endtask

   task automatic test_hold_start;
      for (int i = 0; i < 5; i++) begin
         tick(1'b1);
         checks++;
         if ({state, WER1, trictrl, done} !== {3'd0, 1'b1, 8'h01, 1'b0}) begin
            errors++;
            $display("FAIL hold[%0d]: st=%0d wer1=%b tri=%h done=%b want 0 1 01 0",
                     i, state, WER1, trictrl, done);
         end
      end
   endtask

   task automatic test_restart_done;
      for (int i = 0; i < 8; i++) tick(1'b0);
      checks++;
      if (done !== 1'b1 || state !== 3'd7) begin
         errors++;
         $display("FAIL done_pre: st=%0d done=%b want 7 1", state, done);
      end
      tick(1'b1);
      checks++;
      if (done !== 1'b0 || state !== 3'd0) begin
         errors++;
         $display("FAIL done_restart: st=%0d done=%b want 0 0", state, done);
      end
   endtask

   task automatic test_random;
      logic s;
      for (int i = 0; i < 400; i++) begin
         s = ($urandom_range(0, 9) == 0);
         tick(s);
         checks++;
         if (dut_vec !== exp_vec(m_step)) begin
            errors++;
            $display("FAIL rand[%0d]: got %h want %h",
                     i, dut_vec, exp_vec(m_step));
         end
         checks++;
         if ($countones(trictrl) > 1) begin
            errors++;
            $display("FAIL onehot[%0d]: trictrl %h want at most one bit",
                     i, trictrl);
         end
      end
   endtask

   initial begin
      start = 1'b1;
      test_reset();
      test_sequence();
      test_restart_mid();
      test_hold_start();
      test_restart_done();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
